// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with stall-hold, bubble and flush controls plus
// saturating event counters. Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer.
module pipe_stage_reg #(
   parameter int                DATA_W     = 96,
   parameter int                CTRL_W     = 32,
   parameter logic [CTRL_W-1:0] CTRL_RESET = {CTRL_W{1'b0}},
   parameter int                COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [CTRL_W-1:0]  in_ctrl,
   input  logic               in_stall_hold,
   input  logic               in_stall_bubble,
   input  logic               in_flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic [COUNT_W-1:0] hold_count,
   output logic [COUNT_W-1:0] bubble_count
);

   typedef enum logic [1:0] {
      EV_NORMAL,
      EV_HOLD,
      EV_BUBBLE,
      EV_FLUSH
   } event_t;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + COUNT_W'(1);
   endfunction

   event_t              ev;
   logic                load_en;
   logic                src_vld;
   logic [DATA_W-1:0]   src_data;
   logic [CTRL_W-1:0]   src_ctrl;

   logic                vld_p1;
   logic [DATA_W-1:0]   data_p1;
   logic [CTRL_W-1:0]   ctrl_p1;
   logic [COUNT_W-1:0]  hold_cnt;
   logic [COUNT_W-1:0]  bubble_cnt;

   always_comb begin
      ev = EV_NORMAL;
      if (in_flush)
         ev = EV_FLUSH;
      else if (in_stall_bubble)
         ev = EV_BUBBLE;
      else if (in_stall_hold)
         ev = EV_HOLD;
   end

   assign load_en = (ev == EV_NORMAL) && (!vld_p1 || out_ready);

`ifdef PIPE_STAGE_SKID_EN
   logic                skid_vld_p0;
   logic [DATA_W-1:0]   skid_data_p0;
   logic [CTRL_W-1:0]   skid_ctrl_p0;
   logic                accept;
   logic                skid_wr;
   logic                skid_rd;

   // Ready depends only on skid occupancy and the kill controls, never on out_ready.
   assign in_ready = !skid_vld_p0 && !in_flush && !in_stall_bubble;
   assign accept   = in_valid && in_ready;
   assign skid_wr  = accept && !load_en;
   assign skid_rd  = load_en && skid_vld_p0;
   assign src_vld  = skid_vld_p0 || accept;
   assign src_data = skid_vld_p0 ? skid_data_p0 : in_data;
   assign src_ctrl = skid_vld_p0 ? skid_ctrl_p0 : in_ctrl;

   // Skid stage: parks an accepted payload while the main register cannot load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_vld_p0  <= 1'b0;
         skid_data_p0 <= '0;
         skid_ctrl_p0 <= CTRL_RESET;
      end else if (ev == EV_FLUSH) begin
         skid_vld_p0  <= 1'b0;
         skid_ctrl_p0 <= CTRL_RESET;
      end else if (skid_wr) begin
         skid_vld_p0  <= 1'b1;
         skid_data_p0 <= in_data;
         skid_ctrl_p0 <= in_ctrl;
      end else if (skid_rd) begin
         skid_vld_p0  <= 1'b0;
      end
   end
`else
   assign in_ready = load_en;
   assign src_vld  = in_valid;
   assign src_data = in_data;
   assign src_ctrl = in_ctrl;
`endif

   // Main stage: payload is only overwritten by a live source, so bubbles and flushes keep it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         ctrl_p1 <= CTRL_RESET;
      end else begin
         unique case (ev)
            EV_FLUSH, EV_BUBBLE: begin
               vld_p1  <= 1'b0;
               ctrl_p1 <= CTRL_RESET;
            end
            EV_HOLD: begin
            end
            default: begin
               if (load_en) begin
                  vld_p1  <= src_vld;
                  ctrl_p1 <= src_vld ? src_ctrl : CTRL_RESET;
                  if (src_vld)
                     data_p1 <= src_data;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt   <= '0;
         bubble_cnt <= '0;
      end else begin
         if (ev == EV_HOLD)
            hold_cnt <= sat_inc(hold_cnt);
         if (ev == EV_BUBBLE)
            bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

   assign out_valid    = vld_p1;
   assign out_data     = data_p1;
   assign out_ctrl     = ctrl_p1;
   assign hold_count   = hold_cnt;
   assign bubble_count = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a cycle-level reference model;
// a second instance with COUNT_W=2 exercises counter saturation.
module tb_pipe_stage_reg;

   localparam int DW = 96;
   localparam int CW = 32;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          in_stall_hold;
   logic          in_stall_bubble;
   logic          in_flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [15:0]   hold_count;
   logic [15:0]   bubble_count;

   logic          s_in_ready;
   logic          s_out_valid;
   logic [DW-1:0] s_out_data;
   logic [CW-1:0] s_out_ctrl;
   logic [1:0]    s_hold_count;
   logic [1:0]    s_bubble_count;

   pipe_stage_reg u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_stall_hold(in_stall_hold),
      .in_stall_bubble(in_stall_bubble), .in_flush(in_flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .hold_count(hold_count), .bubble_count(bubble_count)
   );

   pipe_stage_reg #(.COUNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_stall_hold(in_stall_hold),
      .in_stall_bubble(in_stall_bubble), .in_flush(in_flush), .out_valid(s_out_valid),
      .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
      .hold_count(s_hold_count), .bubble_count(s_bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit             m_vld;
   logic [DW-1:0]  m_data;
   logic [CW-1:0]  m_ctrl;
   logic [127:0]   m_skid[$];
   int             m_hold;
   int             m_bub;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_clear();
      m_vld  = 1'b0;
      m_data = '0;
      m_ctrl = '0;
      m_skid.delete();
      m_hold = 0;
      m_bub  = 0;
   endtask

   task automatic check_state();
      check_eq("out_valid", out_valid, m_vld);
      check_eq("out_ctrl", out_ctrl, m_ctrl);
      if (m_vld)
         check_eq("out_data", out_data, m_data);
      check_eq("hold_count", hold_count, sat(m_hold, 16));
      check_eq("bubble_count", bubble_count, sat(m_bub, 16));
      check_eq("sat_hold_count", s_hold_count, sat(m_hold, 2));
      check_eq("sat_bubble_count", s_bubble_count, sat(m_bub, 2));
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input bit h, input bit b, input bit f, input bit r);
      in_valid = v; in_data = d; in_ctrl = c;
      in_stall_hold = h; in_stall_bubble = b; in_flush = f; out_ready = r;
   endtask

   // One clock: inputs already driven just after a negedge; returns at the next negedge.
   task automatic step();
      bit           load;
      bit           exp_rdy;
      bit           acc;
      logic [127:0] e;
      #1;
      load = !m_vld || out_ready;
      if (SKID)
         exp_rdy = (m_skid.size() == 0) && !in_flush && !in_stall_bubble;
      else
         exp_rdy = !in_flush && !in_stall_bubble && !in_stall_hold && load;
      check_eq("in_ready", in_ready, exp_rdy);
      acc = in_valid && exp_rdy;
      if (in_flush) begin
         m_vld = 1'b0; m_ctrl = '0; m_skid.delete();
      end else if (in_stall_bubble) begin
         m_vld = 1'b0; m_ctrl = '0; m_bub++;
      end else if (in_stall_hold) begin
         m_hold++;
         if (SKID && acc) m_skid.push_back({in_data, in_ctrl});
      end else if (load) begin
         if (m_skid.size() != 0) begin
            e = m_skid.pop_front();
            m_vld = 1'b1; m_data = e[127:32]; m_ctrl = e[31:0];
         end else if (in_valid) begin
            m_vld = 1'b1; m_data = in_data; m_ctrl = in_ctrl;
         end else begin
            m_vld = 1'b0; m_ctrl = '0;
         end
      end else if (SKID && acc) begin
         m_skid.push_back({in_data, in_ctrl});
      end
      @(posedge clk);
      #1;
      check_state();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b1, {$urandom, $urandom, $urandom}, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_ctrl", out_ctrl, 32'h0);
      check_eq("rst_out_data", out_data, 96'h0);
      check_eq("rst_hold_count", hold_count, 16'h0);
      check_eq("rst_bubble_count", bubble_count, 16'h0);
      check_eq("rst_sat_hold", s_hold_count, 2'h0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [DW-1:0] saved_data;
      int            saved_hold;
      int            saved_bub;
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      do_reset();

      // first load after reset release
      drive(1'b1, 96'hA5, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check_eq("first_valid", out_valid, 1'b1);
      check_eq("first_data", out_data, 96'hA5);

      // back-to-back stream
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 96'h100 + DW'(i), 32'h1 + CW'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         step();
         check_eq("stream_data", out_data, 96'h100 + DW'(i));
      end

      // hold three cycles while upstream keeps offering
      do_reset();
      drive(1'b1, rnd_data(), 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      saved_data = out_data;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rnd_data(), 32'h60 + CW'(i), 1'b1, 1'b0, 1'b0, i[0]);
         step();
         check_eq("hold_data", out_data, saved_data);
      end
      check_eq("hold_cnt3", hold_count, 16'd3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, rnd_data(), 32'h70 + CW'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         step();
      end

      // bubble on a valid stage, then the same payload presented again
      do_reset();
      drive(1'b1, rnd_data(), 32'h77, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      saved_data = out_data;
      drive(1'b1, 96'hBEEF, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      check_eq("bub_valid", out_valid, 1'b0);
      check_eq("bub_ctrl", out_ctrl, 32'h0);
      check_eq("bub_data", out_data, saved_data);
      check_eq("bub_count", bubble_count, 16'd1);
      drive(1'b1, 96'hBEEF, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check_eq("bub_retry_data", out_data, 96'hBEEF);

      // flush + bubble + hold with the skid occupied
      drive(1'b1, rnd_data(), 32'h88, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      saved_hold = m_hold;
      saved_bub  = m_bub;
      drive(1'b1, rnd_data(), 32'h99, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      check_eq("fbh_valid", out_valid, 1'b0);
      check_eq("fbh_hold", hold_count, 16'(saved_hold));
      check_eq("fbh_bubble", bubble_count, 16'(saved_bub));
      drive(1'b0, rnd_data(), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check_eq("fbh_skid_empty", out_valid, 1'b0);

      // saturation of the narrow counter
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, rnd_data(), 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
         step();
      end
      check_eq("sat_hold3", s_hold_count, 2'd3);
      check_eq("wide_hold5", hold_count, 16'd5);

      // asynchronous reset between edges
      drive(1'b1, rnd_data(), 32'hABCD, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_valid", out_valid, 1'b0);
      check_eq("arst_ctrl", out_ctrl, 32'h0);
      check_eq("arst_data", out_data, 96'h0);
      check_eq("arst_hold", hold_count, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      model_clear();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom % 4) != 0, rnd_data(), $urandom,
               ($urandom % 100) < 15, ($urandom % 100) < 8,
               ($urandom % 100) < 4, ($urandom % 100) < 70);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
